writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk input 1 (all state updates on rising edge); Reset input 1 (synchronous, active-high).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- PCIn, input, 32: link value from MEM/WB.
- ReadDataIn, input, 32: memory load data.
- ALUIn, input, 32: ALU result.
- RegDstIn, input, 5: destination register.
- MemToRegIn, input, 2: writeback source select.
- RegWriteMuxIn, input, 1: 1 forces destination to $31.
- RegWriteIn, input, 1: write enable.
- ReadReg1, ReadReg2, inputs, 5 each: decode-stage read addresses.
- ReadData1, ReadData2, outputs, 32 each: read data.
- WriteAddrOut, output, 5: effective destination, to the forwarding unit.
- WriteDataOut, output, 32: selected writeback data.
- WriteEnOut, output, 1: effective write, to the forwarding unit.
- RetireCount, output, 32: count of effective writes.
- DisplayOut, output, 32: last value written.

Function
REQ-003 The block SHALL select WriteDataOut combinationally: MemToRegIn 00 -> ALUIn, 01 -> ReadDataIn, 10 -> PCIn, 11 -> ALUIn (reserved).
REQ-004 The block SHALL compute WriteAddrOut = 31 when RegWriteMuxIn=1, else RegDstIn.
REQ-005 The block SHALL drive WriteEnOut = RegWriteIn AND (WriteAddrOut != 0).
REQ-006 The block SHALL write WriteDataOut into register WriteAddrOut on the rising Clk edge when WriteEnOut=1 and Reset=0.
REQ-007 The block SHALL never modify register $0, and reads of $0 SHALL return 0 in all cases.
REQ-008 The block SHALL return the array content combinationally on ReadData1/ReadData2.
REQ-009 When WriteEnOut=1 and a read address equals WriteAddrOut, that read port SHALL return WriteDataOut in the same cycle (write-before-read bypass), applied independently per port.
REQ-010 The block SHALL give writes a latency of one edge; a non-bypassed read SHALL see the new value from the following cycle.
REQ-011 RetireCount SHALL increment by 1 on each edge with WriteEnOut=1 and wrap from 0xFFFFFFFF to 0.
REQ-012 RetireCount SHALL NOT increment for writes to $0 or for RegWriteIn=0.
REQ-013 DisplayOut SHALL be registered and SHALL load WriteDataOut on each edge with WriteEnOut=1, holding its value otherwise.
REQ-014 When both read ports address the same register, both SHALL return identical data, including the bypass case.

Reset
REQ-015 On a rising edge with Reset=1, all 32 registers, RetireCount and DisplayOut SHALL become 0.
REQ-016 Reset SHALL take priority over a simultaneous write: no register is written and the counter is not incremented.
REQ-017 The combinational outputs WriteDataOut, WriteAddrOut and WriteEnOut SHALL follow their inputs even during reset.
REQ-018 ReadData1/ReadData2 SHALL return 0 for every address in the cycle after reset, except where the REQ-009 bypass applies.

Structure
REQ-019 A shared package SHALL hold the MemToReg encodings (MTR_ALU=00, MTR_MEM=01, MTR_LINK=10) and the constants REG_ZERO=0 and REG_RA=31.
REQ-020 The 32x32 storage array, with its two read ports and bypass, SHALL be a sub-module named regfile_32x32.
REQ-021 The writeback mux, destination select, counter and display register SHALL reside in the top level.

Verification
REQ-022 Scenario: Reset=1 for one edge with RegWriteIn=1 and dest 5, then read $5 -> ReadData=0, RetireCount=0, DisplayOut=0.
REQ-023 Scenario: MemToRegIn=01, ReadDataIn=0xDEADBEEF, RegDstIn=8, RegWriteIn=1 -> ReadReg1=8 returns 0xDEADBEEF in the same cycle via bypass and on the next cycle from the array; RetireCount=1; DisplayOut=0xDEADBEEF.
REQ-024 Scenario: RegWriteMuxIn=1, MemToRegIn=10, PCIn=0x00400010, RegDstIn=3 -> $31=0x00400010 and $3 unchanged.
REQ-025 Scenario: RegWriteIn=1, RegDstIn=0, ALUIn=0x12345678 -> $0 reads 0, WriteEnOut=0, RetireCount unchanged, DisplayOut unchanged.
REQ-026 Scenario: preload RetireCount to 0xFFFFFFFF through 2^32-1 writes (or a forced value), then one write -> RetireCount=0.
REQ-027 Scenario: ReadReg1=ReadReg2=9 while writing 0xA5A5A5A5 to $9 -> both ports return 0xA5A5A5A5; a simultaneous Reset=1 leaves $9=0 after the edge.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared writeback encodings and constants.
// Imported by the writeback top and its register array.
package writeback_regfile_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11
    } mtr_e;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_RA   = 5'd31;

    // Effective write request handed from the mux stage to the array
    typedef struct packed {
        logic            en;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register array, two combinational read ports with
// write-before-read bypass; $0 is hardwired to zero.
module regfile_32x32
    import writeback_regfile_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_wr_ok;
    logic            w_hit1;
    logic            w_hit2;

    assign w_wr_ok = i_we && (i_waddr != REG_ZERO);
    assign w_hit1  = w_wr_ok && (i_raddr1 == i_waddr);
    assign w_hit2  = w_wr_ok && (i_raddr2 == i_waddr);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass is applied even while Reset is high
    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        if (i_raddr1 == REG_ZERO) begin
            o_rdata1 = '0;
        end else if (w_hit1) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_mem[i_raddr2];
        if (i_raddr2 == REG_ZERO) begin
            o_rdata2 = '0;
        end else if (w_hit2) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: source mux, destination select, retire counter,
// display register, and the architectural register file.
module writeback_regfile
    import writeback_regfile_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [XLEN-1:0] PCIn,
    input  logic [XLEN-1:0] ReadDataIn,
    input  logic [XLEN-1:0] ALUIn,
    input  logic [AW-1:0]   RegDstIn,
    input  logic [1:0]      MemToRegIn,
    input  logic            RegWriteMuxIn,
    input  logic            RegWriteIn,
    input  logic [AW-1:0]   ReadReg1,
    input  logic [AW-1:0]   ReadReg2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic [AW-1:0]   WriteAddrOut,
    output logic [XLEN-1:0] WriteDataOut,
    output logic            WriteEnOut,
    output logic [XLEN-1:0] RetireCount,
    output logic [XLEN-1:0] DisplayOut
);

    wb_req_t         w_wb;
    logic [XLEN-1:0] w_wdata;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] r_count;
    logic [XLEN-1:0] r_disp;

    always_comb begin
        w_wdata = ALUIn;
        case (mtr_e'(MemToRegIn))
            MTR_ALU:  w_wdata = ALUIn;
            MTR_MEM:  w_wdata = ReadDataIn;
            MTR_LINK: w_wdata = PCIn;
            default:  w_wdata = ALUIn;
        endcase
    end

    assign w_waddr = RegWriteMuxIn ? REG_RA : RegDstIn;

    assign w_wb.en   = RegWriteIn && (w_waddr != REG_ZERO);
    assign w_wb.addr = w_waddr;
    assign w_wb.data = w_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
            r_disp  <= '0;
        end else if (w_wb.en) begin
            r_count <= r_count + 1'b1;
            r_disp  <= w_wb.data;
        end
    end

    regfile_32x32 u_rf (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_we     (w_wb.en),
        .i_waddr  (w_wb.addr),
        .i_wdata  (w_wb.data),
        .i_raddr1 (ReadReg1),
        .i_raddr2 (ReadReg2),
        .o_rdata1 (ReadData1),
        .o_rdata2 (ReadData2)
    );

    assign WriteAddrOut = w_wb.addr;
    assign WriteDataOut = w_wb.data;
    assign WriteEnOut   = w_wb.en;
    assign RetireCount  = r_count;
    assign DisplayOut   = r_disp;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed + light random bench for writeback_regfile, checked
// every cycle against an architectural register-file model.
module tb_writeback_regfile;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCIn;
    logic [31:0] ReadDataIn;
    logic [31:0] ALUIn;
    logic [4:0]  RegDstIn;
    logic [1:0]  MemToRegIn;
    logic        RegWriteMuxIn;
    logic        RegWriteIn;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WriteAddrOut;
    logic [31:0] WriteDataOut;
    logic        WriteEnOut;
    logic [31:0] RetireCount;
    logic [31:0] DisplayOut;

    writeback_regfile dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .PCIn          (PCIn),
        .ReadDataIn    (ReadDataIn),
        .ALUIn         (ALUIn),
        .RegDstIn      (RegDstIn),
        .MemToRegIn    (MemToRegIn),
        .RegWriteMuxIn (RegWriteMuxIn),
        .RegWriteIn    (RegWriteIn),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteAddrOut  (WriteAddrOut),
        .WriteDataOut  (WriteDataOut),
        .WriteEnOut    (WriteEnOut),
        .RetireCount   (RetireCount),
        .DisplayOut    (DisplayOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;
    bit preload = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count = '0;
    logic [31:0] m_disp = '0;

    bit          pin_rd1_en = 0;
    logic [31:0] pin_rd1;
    bit          pin_rd2_en = 0;
    logic [31:0] pin_rd2;
    bit          pin_cnt_en = 0;
    logic [31:0] pin_cnt;
    bit          pin_disp_en = 0;
    logic [31:0] pin_disp;
    bit          pin_we_en = 0;
    logic        pin_we;

    function automatic logic [31:0] exp_wdata();
        if (MemToRegIn == 2'd1) return ReadDataIn;
        if (MemToRegIn == 2'd2) return PCIn;
        return ALUIn;
    endfunction

    function automatic logic [4:0] exp_waddr();
        return RegWriteMuxIn ? 5'd31 : RegDstIn;
    endfunction

    function automatic logic exp_we();
        return RegWriteIn && (exp_waddr() != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (exp_we() && a == exp_waddr()) return exp_wdata();
        return m_regs[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare();
        logic [31:0] ecnt;
        ecnt = preload ? 32'hFFFF_FFFF : m_count;
        chk("wdata", WriteDataOut, exp_wdata());
        chk("waddr", {27'd0, WriteAddrOut}, {27'd0, exp_waddr()});
        chk("we", {31'd0, WriteEnOut}, {31'd0, exp_we()});
        chk("rd1", ReadData1, exp_read(ReadReg1));
        chk("rd2", ReadData2, exp_read(ReadReg2));
        chk("count", RetireCount, ecnt);
        chk("disp", DisplayOut, m_disp);
        if (pin_rd1_en) chk("pin_rd1", ReadData1, pin_rd1);
        if (pin_rd2_en) chk("pin_rd2", ReadData2, pin_rd2);
        if (pin_cnt_en) chk("pin_cnt", RetireCount, pin_cnt);
        if (pin_disp_en) chk("pin_disp", DisplayOut, pin_disp);
        if (pin_we_en) chk("pin_we", {31'd0, WriteEnOut}, {31'd0, pin_we});
    endtask

    task automatic model_step();
        logic [31:0] base;
        base = preload ? 32'hFFFF_FFFF : m_count;
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_count = '0;
            m_disp = '0;
        end else begin
            m_count = base;
            if (exp_we()) begin
                m_regs[exp_waddr()] = exp_wdata();
                m_count = base + 32'd1;
                m_disp = exp_wdata();
            end
        end
    endtask

    task automatic apply(input logic rst, input logic [31:0] pc,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] dst, input logic [1:0] mtr,
                         input logic mux, input logic rw,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge Clk);
        Reset = rst;
        PCIn = pc;
        ReadDataIn = rd;
        ALUIn = alu;
        RegDstIn = dst;
        MemToRegIn = mtr;
        RegWriteMuxIn = mux;
        RegWriteIn = rw;
        ReadReg1 = r1;
        ReadReg2 = r2;
        if (preload) begin
            force dut.r_count = 32'hFFFF_FFFF;
            #1;
            release dut.r_count;
            #2;
        end else begin
            #3;
        end
        if (chk_en) compare();
        @(posedge Clk);
        model_step();
        preload = 1'b0;
        pin_rd1_en = 0;
        pin_rd2_en = 0;
        pin_cnt_en = 0;
        pin_disp_en = 0;
        pin_we_en = 0;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        apply(0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0, 0, r1, r2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        Reset = 0; PCIn = 0; ReadDataIn = 0; ALUIn = 0; RegDstIn = 0;
        MemToRegIn = 0; RegWriteMuxIn = 0; RegWriteIn = 0;
        ReadReg1 = 0; ReadReg2 = 0;

        // Reset with a competing write to $5
        apply(1, 0, 0, 32'h1234, 5'd5, 2'd0, 0, 1, 5'd5, 5'd0);
        chk_en = 1'b1;
        pin_rd1_en = 1; pin_rd1 = 32'h0;
        pin_cnt_en = 1; pin_cnt = 32'h0;
        pin_disp_en = 1; pin_disp = 32'h0;
        idle(5'd5, 5'd0);

        // Load to $8, bypass then array read
        pin_rd1_en = 1; pin_rd1 = 32'hDEAD_BEEF;
        apply(0, 0, 32'hDEAD_BEEF, 32'h1111, 5'd8, 2'd1, 0, 1, 5'd8, 5'd5);
        pin_rd1_en = 1; pin_rd1 = 32'hDEAD_BEEF;
        pin_cnt_en = 1; pin_cnt = 32'd1;
        pin_disp_en = 1; pin_disp = 32'hDEAD_BEEF;
        idle(5'd8, 5'd8);

        // Link write forced to $31, $3 untouched
        apply(0, 0, 0, 32'h3333_3333, 5'd3, 2'd0, 0, 1, 5'd3, 5'd0);
        pin_rd1_en = 1; pin_rd1 = 32'h0040_0010;
        pin_rd2_en = 1; pin_rd2 = 32'h3333_3333;
        apply(0, 32'h0040_0010, 0, 32'h9, 5'd3, 2'd2, 1, 1, 5'd31, 5'd3);
        pin_rd1_en = 1; pin_rd1 = 32'h0040_0010;
        pin_rd2_en = 1; pin_rd2 = 32'h3333_3333;
        pin_cnt_en = 1; pin_cnt = 32'd3;
        idle(5'd31, 5'd3);

        // Write to $0 is dropped
        pin_we_en = 1; pin_we = 1'b0;
        pin_rd1_en = 1; pin_rd1 = 32'h0;
        apply(0, 0, 0, 32'h1234_5678, 5'd0, 2'd0, 0, 1, 5'd0, 5'd0);
        pin_cnt_en = 1; pin_cnt = 32'd3;
        pin_disp_en = 1; pin_disp = 32'h0040_0010;
        idle(5'd0, 5'd31);

        // Reserved select, and a disabled write
        apply(0, 32'h5, 32'h6, 32'hCAFE_F00D, 5'd10, 2'd3, 0, 1, 5'd10, 5'd11);
        apply(0, 32'h5, 32'h6, 32'h7777_0000, 5'd11, 2'd0, 0, 0, 5'd11, 5'd10);
        pin_rd1_en = 1; pin_rd1 = 32'h0;
        pin_rd2_en = 1; pin_rd2 = 32'hCAFE_F00D;
        idle(5'd11, 5'd10);

        // Counter wrap from a preloaded all-ones value
        preload = 1'b1;
        pin_cnt_en = 1; pin_cnt = 32'hFFFF_FFFF;
        apply(0, 0, 0, 32'h77, 5'd12, 2'd0, 0, 1, 5'd12, 5'd0);
        pin_cnt_en = 1; pin_cnt = 32'h0;
        pin_disp_en = 1; pin_disp = 32'h77;
        idle(5'd12, 5'd0);

        // Same-register dual read, then write under reset
        apply(0, 0, 0, 32'h1111_1111, 5'd9, 2'd0, 0, 1, 5'd9, 5'd9);
        pin_rd1_en = 1; pin_rd1 = 32'hA5A5_A5A5;
        pin_rd2_en = 1; pin_rd2 = 32'hA5A5_A5A5;
        apply(1, 0, 0, 32'hA5A5_A5A5, 5'd9, 2'd0, 0, 1, 5'd9, 5'd9);
        pin_rd1_en = 1; pin_rd1 = 32'h0;
        pin_rd2_en = 1; pin_rd2 = 32'h0;
        pin_cnt_en = 1; pin_cnt = 32'h0;
        idle(5'd9, 5'd9);

        for (int k = 0; k < 40; k++) begin
            apply(($urandom_range(0, 19) == 0), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
